// File: rtl/ram_ctrl_pkg.sv
// Shared types and default widths for the ram_ctrl burst initiator.
// RAM_CTRL_CLEAR_EN adds the CLR state used by the memory-clear command.
package ram_ctrl_pkg;
  localparam int DW_DEF = 32;
  localparam int AW_DEF = 6;
  localparam int LW_DEF = 6;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_DATA,
    DONE
`ifdef RAM_CTRL_CLEAR_EN
    , CLR
`endif
  } state_t;
endpackage

// File: rtl/ram_ctrl_addr_gen.sv
// Loadable address/remaining-beat counter pair shared by every burst type.
module ram_ctrl_addr_gen #(
  parameter int AW = 6,
  parameter int RW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] load_addr,
  input  logic [RW-1:0] load_len,
  output logic [AW-1:0] cur_addr,
  output logic [AW-1:0] next_addr,
  output logic          last
);
  logic [RW-1:0] remaining;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= '0;
      remaining <= '0;
    end else if (load) begin
      cur_addr  <= load_addr;
      remaining <= load_len;
    end else if (step) begin
      cur_addr  <= cur_addr + AW'(1);
      remaining <= remaining - RW'(1);
    end
  end

  // address arithmetic wraps modulo 2^AW by construction
  assign next_addr = cur_addr + AW'(1);
  assign last      = (remaining == '0);
endmodule

// File: rtl/ram_ctrl.sv
// Burst RAM initiator: one read/write command at a time, streams beats to/from the RAM.
// Optional RAM_CTRL_CLEAR_EN adds a cmd_clear command that zeroes the whole array.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// WR      | accepting write beats, one RAM write per handshake
// RD_ADDR | RAM address registered, waiting for q
// RD_DATA | read beat presented, held until rd_ready
// DONE    | last write lands (write path), then one-cycle done pulse
// CLR     | writing zero to every address (RAM_CTRL_CLEAR_EN only)
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
`ifdef RAM_CTRL_CLEAR_EN
  input  logic          cmd_clear,
`endif
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  input  logic [DW-1:0] mem_q
);
  localparam int RW = (LW > AW) ? LW : AW;

  state_t        state;
  logic          cmd_fire;
  logic          wr_fire;
  logic          ag_step;
  logic [AW-1:0] ag_addr_in;
  logic [RW-1:0] ag_len_in;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] next_addr;
  logic          last;

  assign rd_data  = mem_q;
  assign cmd_fire = cmd_valid && cmd_ready;
  assign wr_fire  = wr_valid && wr_ready;

  always_comb begin
    ag_addr_in = cmd_addr;
    ag_len_in  = RW'(cmd_len);
`ifdef RAM_CTRL_CLEAR_EN
    if (cmd_clear) begin
      ag_addr_in = '0;
      ag_len_in  = RW'((2 ** AW) - 1);
    end
`endif
    ag_step = 1'b0;
    case (state)
      WR:      ag_step = wr_fire;
      RD_DATA: ag_step = rd_ready;
`ifdef RAM_CTRL_CLEAR_EN
      CLR:     ag_step = 1'b1;
`endif
      default: ag_step = 1'b0;
    endcase
  end

  ram_ctrl_addr_gen #(.AW(AW), .RW(RW)) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cmd_fire),
    .step      (ag_step),
    .load_addr (ag_addr_in),
    .load_len  (ag_len_in),
    .cur_addr  (cur_addr),
    .next_addr (next_addr),
    .last      (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
`ifdef RAM_CTRL_CLEAR_EN
            if (cmd_clear) state <= CLR;
            else
`endif
            if (cmd_write) begin
              state    <= WR;
              wr_ready <= 1'b1;
            end else begin
              // address goes out now so q is valid when RD_DATA starts
              state    <= RD_ADDR;
              mem_addr <= cmd_addr;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WR: begin
          if (wr_fire) begin
            mem_we   <= 1'b1;
            mem_addr <= cur_addr;
            mem_data <= wr_data;
            if (last) begin
              state    <= DONE;
              wr_ready <= 1'b0;
            end
          end
        end
        RD_ADDR: begin
          state    <= RD_DATA;
          rd_valid <= 1'b1;
        end
        RD_DATA: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= RD_ADDR;
              mem_addr <= next_addr;
            end
          end
        end
`ifdef RAM_CTRL_CLEAR_EN
        CLR: begin
          mem_we   <= 1'b1;
          mem_addr <= cur_addr;
          mem_data <= '0;
          if (last) state <= DONE;
        end
`endif
        DONE: begin
          // write paths arrive with done low: let the last write land first
          if (done) begin
            done      <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl with a behavioural RAM and a command-level reference model.
module tb_ram_ctrl;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int LW = 6;
  localparam int N  = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
`ifdef RAM_CTRL_CLEAR_EN
  logic          cmd_clear = 1'b0;
`endif
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_q;

  always #5 clk = ~clk;

  ram_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
`ifdef RAM_CTRL_CLEAR_EN
    .cmd_clear (cmd_clear),
`endif
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_q     (mem_q)
  );

  // single-port RAM: write, or registered read of a non-write address
  logic [DW-1:0] mem [N];
  logic [DW-1:0] q = '0;
  assign mem_q = q;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
    else        q <= mem[mem_addr];
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  int done_cnt = 0;
  logic ready_seen = 1'b0;

  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} wbeat_t;
  wbeat_t        wq[$];
  logic [DW-1:0] rq[$];
  logic [DW-1:0] ref_mem [N];

  always @(posedge clk) cyc++;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endfunction

  function automatic void model_write(input int addr, input int beats, input logic [DW-1:0] base,
                                      input int inc, input int commit);
    for (int i = 0; i < beats; i++) begin
      wbeat_t b;
      b.a = AW'((addr + i) % N);
      b.d = base + DW'(inc * i);
      wq.push_back(b);
      if (i < commit) ref_mem[(addr + i) % N] = b.d;
    end
  endfunction

  function automatic void model_read(input int addr, input int beats);
    for (int i = 0; i < beats; i++) rq.push_back(ref_mem[(addr + i) % N]);
  endfunction

  // per-cycle comparison against the reference model
  always @(negedge clk) begin
    if (!rst_n) begin
      ready_seen = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (cmd_ready) ready_seen = 1'b1;
      if (ready_seen) check("ready_vs_busy", cmd_ready, !busy);
      if (mem_we) begin
        if (wq.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_write: addr %0d data %0h, required no write", mem_addr, mem_data);
        end else begin
          wbeat_t b;
          b = wq.pop_front();
          check("wr_addr", mem_addr, b.a);
          check("wr_data", mem_data, b.d);
        end
      end
      if (rd_valid) begin
        if (rq.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_read: rd_data %0h, required no beat", rd_data);
        end else begin
          check("rd_data", rd_data, rq[0]);
          if (rd_ready) void'(rq.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input int addr, input int len, input logic hold, output int acc);
    logic hs;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = AW'(addr);
    cmd_len   = LW'(len);
    acc = -1;
    for (int t = 0; t < 40; t++) begin
      hs = cmd_ready;
      tick();
      if (hs) begin
        acc = cyc;
        break;
      end
    end
    if (!hold) cmd_valid = 1'b0;
    if (acc < 0) begin
      chk_cnt++;
      $display("FAIL cmd_accept: no handshake, required one");
    end
  endtask

  task automatic send_wr(input int beats, input logic [DW-1:0] base, input int inc);
    logic hs;
    for (int b = 0; b < beats; b++) begin
      wr_valid = 1'b1;
      wr_data  = base + DW'(inc * b);
      hs = 1'b0;
      for (int t = 0; t < 40 && !hs; t++) begin
        hs = wr_ready;
        tick();
      end
      if (!hs) begin
        chk_cnt++;
        $display("FAIL wr_handshake: beat %0d not taken, required taken", b);
        break;
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic get_rd(input int beats, input int stall_beat, input int stall_n,
                        input logic [DW-1:0] stall_val, output int first);
    first = -1;
    for (int b = 0; b < beats; b++) begin
      for (int t = 0; t < 40 && !rd_valid; t++) tick();
      if (!rd_valid) begin
        chk_cnt++;
        $display("FAIL rd_wait: beat %0d never valid, required valid", b);
        return;
      end
      if (b == 0) first = cyc;
      if (b == stall_beat) begin
        for (int s = 0; s < stall_n; s++) begin
          check("stall_valid", rd_valid, 1'b1);
          check("stall_data", rd_data, stall_val);
          tick();
        end
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int t = 0; t < 200; t++) begin
      if (done) begin
        at = cyc;
        break;
      end
      tick();
    end
    if (at < 0) begin
      chk_cnt++;
      $display("FAIL done_wait: no done pulse, required one");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, d, first, dc0, nz;
    for (int i = 0; i < N; i++) begin
      mem[i]     = 32'h5500_0000 + DW'(i);
      ref_mem[i] = 32'h5500_0000 + DW'(i);
    end

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_mem_addr", mem_addr, 6'd0);
    rst_n = 1'b1;
    check("rel_cmd_ready_low", cmd_ready, 1'b0);
    tick();
    check("rel_cmd_ready_high", cmd_ready, 1'b1);

    // write burst addr 4, 4 beats
    model_write(4, 4, 32'hA0, 1, 4);
    issue(1'b1, 4, 3, 1'b0, acc);
    send_wr(4, 32'hA0, 1);
    wait_done(d);
    check("wr_latency", d - acc + 1, 6);
    tick();
    check("done_one_cycle", done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("no_we_after_done", mem_we, 1'b0);
      tick();
    end
    check("ram4", mem[4], 32'hA0);
    check("ram5", mem[5], 32'hA1);
    check("ram6", mem[6], 32'hA2);
    check("ram7", mem[7], 32'hA3);

    // read burst with a 5-cycle stall on beat 1
    model_read(4, 4);
    dc0 = done_cnt;
    issue(1'b0, 4, 3, 1'b0, acc);
    get_rd(4, 1, 5, 32'hA1, first);
    wait_done(d);
    check("rd_first_valid", first - acc + 1, 2);
    check("rd_stall_latency", d - acc + 1, 14);
    tick();
    tick();
    check("done_once", done_cnt - dc0, 1);
    check("rd_queue_empty", rq.size(), 0);

    // wrapping write at 62 and read-back
    model_write(62, 4, 32'hC0DE_0000, 1, 4);
    issue(1'b1, 62, 3, 1'b0, acc);
    send_wr(4, 32'hC0DE_0000, 1);
    wait_done(d);
    check("wrap_wr_latency", d - acc + 1, 6);
    tick();
    check("wrap62", mem[62], 32'hC0DE_0000);
    check("wrap63", mem[63], 32'hC0DE_0001);
    check("wrap0", mem[0], 32'hC0DE_0002);
    check("wrap1", mem[1], 32'hC0DE_0003);
    check("wrap2_untouched", mem[2], 32'h5500_0002);
    model_read(62, 4);
    issue(1'b0, 62, 3, 1'b0, acc);
    get_rd(4, -1, 0, '0, first);
    wait_done(d);
    check("rd_latency", d - acc + 1, 9);
    tick();

    // command backpressure: cmd_valid held through a write, then a read is taken
    model_write(20, 2, 32'h1111_0000, 1, 2);
    model_read(20, 2);
    issue(1'b1, 20, 1, 1'b1, acc);
    cmd_write = 1'b0;
    send_wr(2, 32'h1111_0000, 1);
    for (int t = 0; t < 20; t++) begin
      check("bp_busy", busy, 1'b1);
      check("bp_ready_low", cmd_ready, 1'b0);
      if (done) break;
      tick();
    end
    tick();
    check("bp_ready_after_done", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    acc = cyc;
    check("bp_second_taken", busy, 1'b1);
    check("bp_second_is_read", wr_ready, 1'b0);
    get_rd(2, -1, 0, '0, first);
    wait_done(d);
    check("bp_rd_latency", d - acc + 1, 5);
    tick();

    // reset in the middle of a write burst
    model_write(10, 4, 32'hB0, 1, 2);
    issue(1'b1, 10, 3, 1'b0, acc);
    wr_valid = 1'b1;
    wr_data = 32'hB0;
    tick();
    wr_data = 32'hB1;
    tick();
    wr_data = 32'hB2;
    tick();
    check("mid_we_before_rst", mem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_we_async", mem_we, 1'b0);
    check("rst_busy_async", busy, 1'b0);
    wr_valid = 1'b0;
    wq.delete();
    rq.delete();
    tick();
    tick();
    check("rst_ram10", mem[10], 32'hB0);
    check("rst_ram11", mem[11], 32'hB1);
    check("rst_ram12", mem[12], 32'h5500_000C);
    check("rst_ram13", mem[13], 32'h5500_000D);
    rst_n = 1'b1;
    tick();
    check("rel2_cmd_ready", cmd_ready, 1'b1);

`ifdef RAM_CTRL_CLEAR_EN
    model_write(0, N, 32'hFF, 0, N);
    issue(1'b1, 0, N - 1, 1'b0, acc);
    send_wr(N, 32'hFF, 0);
    wait_done(d);
    check("fill_latency", d - acc + 1, 66);
    tick();
    model_write(0, N, 32'h0, 0, N);
    cmd_clear = 1'b1;
    issue(1'b0, 17, 5, 1'b0, acc);
    cmd_clear = 1'b0;
    wait_done(d);
    check("clr_latency", d - acc + 1, 66);
    tick();
    nz = 0;
    for (int i = 0; i < N; i++) if (mem[i] != '0) nz++;
    check("clr_nonzero_words", nz, 0);
`endif

    check("wq_drained", wq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
